// File: rtl/vga_timing_pkg.sv
// Shared 800x600@72 timing constants for the timing generator and the line fetch buffer,
// plus the fetch FSM encodings used by line_fetch_buffer.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE     = 800;
    localparam int unsigned H_SYNC_START = 856;
    localparam int unsigned H_SYNC_END   = 976;
    localparam int unsigned H_TOTAL      = 1040;

    localparam int unsigned V_ACTIVE     = 600;
    localparam int unsigned V_SYNC_START = 637;
    localparam int unsigned V_SYNC_END   = 643;
    localparam int unsigned V_TOTAL      = 666;

    localparam int unsigned HC_W   = 11;
    localparam int unsigned VC_W   = 10;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned RGB_W  = 9;
    localparam int unsigned URUN_W = 16;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam logic [1:0] LFB_IDLE  = 2'd0;
    localparam logic [1:0] LFB_FETCH = 2'd1;
    localparam logic [1:0] LFB_DONE  = 2'd2;

endpackage

// File: rtl/line_fetch_buffer_if.sv
// Frame-memory read port: the buffer is the master issuing requests, the memory answers with a one-cycle ack.
interface line_fetch_buffer_if;
    import vga_timing_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [RGB_W-1:0]  mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);

endinterface

// File: rtl/line_ram.sv
// Two line banks in one array: one write port, one synchronous read port, addressed as {bank, x}.
module line_ram #(
    parameter int unsigned DEPTH = 800,
    parameter int unsigned X_W   = 10,
    parameter int unsigned W     = 9
) (
    input  logic         clk,
    input  logic         we,
    input  logic [X_W:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [X_W:0] raddr,
    output logic [W-1:0] rdata
);
    localparam int unsigned AW = $clog2(2 * DEPTH);

    logic [W-1:0]  mem [2 * DEPTH];
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;

    // Bank 1 starts at DEPTH so the array stays exactly two lines deep for non-power-of-two widths.
    assign widx = (waddr[X_W] ? AW'(DEPTH) : '0) + AW'(waddr[X_W-1:0]);
    assign ridx = (raddr[X_W] ? AW'(DEPTH) : '0) + AW'(raddr[X_W-1:0]);

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
        if (re) rdata <= mem[ridx];
    end

endmodule

// File: rtl/line_fetch_buffer.sv
// Double-buffered scanline fetch: prefetches the next line from frame memory into one bank while
// the other bank is displayed; lines that are not fully fetched in time show ERR_RGB and are counted.
module line_fetch_buffer
    import vga_timing_pkg::*;
#(
    parameter int unsigned      H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned      V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned      V_TOTAL  = vga_timing_pkg::V_TOTAL,
    parameter logic [RGB_W-1:0] ERR_RGB  = 9'b111_000_111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_ce,
    input  logic [HC_W-1:0]     h_count,
    input  logic [VC_W-1:0]     v_count,
    line_fetch_buffer_if.master mem,
    output logic [2:0]          red_out,
    output logic [2:0]          green_out,
    output logic [2:0]          blue_out,
    output logic [URUN_W-1:0]   underrun_cnt
);
    localparam int unsigned       X_W          = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [HC_W-1:0]   H_END        = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0]   V_END        = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]   V_LAST_FETCH = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0]   V_LAST       = VC_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]    X_LAST       = X_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP    = ADDR_W'(H_ACTIVE);

    logic [1:0]        state;
    logic [X_W-1:0]    x_fetch;
    logic [ADDR_W-1:0] base;
    logic              fetch_bank;
    logic [1:0]        bank_ok;
    logic              line_start;
    logic              trig;
    logic              disp_active;
    logic              wr_en;
    logic              act_q;
    logic              ok_q;
    rgb_t              ram_rdata;
    rgb_t              pix;

    assign line_start  = pix_ce && (h_count == '0);
    assign trig        = line_start && ((v_count < V_LAST_FETCH) || (v_count == V_LAST));
    assign disp_active = (h_count < H_END) && (v_count < V_END);
    assign wr_en       = (state == LFB_FETCH) && mem.mem_ack && !trig;

    assign mem.mem_req  = (state == LFB_FETCH);
    assign mem.mem_addr = base + ADDR_W'(x_fetch);

    // A trigger wins in every state: an ack arriving with it is dropped, and a trigger landing on
    // the DONE cycle still starts the next fetch so the base accumulator never skips a line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LFB_IDLE;
            x_fetch    <= '0;
            base       <= '0;
            fetch_bank <= 1'b0;
            bank_ok    <= '0;
        end else if (trig) begin
            state                <= LFB_FETCH;
            x_fetch              <= '0;
            fetch_bank           <= ~v_count[0];
            bank_ok[~v_count[0]] <= 1'b0;
            base                 <= (v_count == V_LAST) ? '0 : base + LINE_STEP;
        end else begin
            case (state)
                LFB_FETCH: begin
                    if (mem.mem_ack) begin
                        x_fetch <= x_fetch + 1'b1;
                        if (x_fetch == X_LAST) begin
                            state               <= LFB_DONE;
                            bank_ok[fetch_bank] <= 1'b1;
                        end
                    end
                end
                default: state <= LFB_IDLE;
            endcase
        end
    end

    line_ram #(
        .DEPTH (H_ACTIVE),
        .X_W   (X_W),
        .W     (RGB_W)
    ) u_line_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({fetch_bank, x_fetch}),
        .wdata (mem.mem_rdata),
        .re    (pix_ce && disp_active),
        .raddr ({v_count[0], h_count[X_W-1:0]}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q        <= 1'b0;
            ok_q         <= 1'b0;
            underrun_cnt <= '0;
        end else if (pix_ce) begin
            act_q <= disp_active;
            ok_q  <= bank_ok[v_count[0]];
            if (line_start && (v_count < V_END) && !bank_ok[v_count[0]] && (underrun_cnt != '1))
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    // The RAM read register and the select flags load on the same pix_ce edge, so the colour
    // only changes on pixel strobes.
    assign pix = !act_q ? '0 : (ok_q ? ram_rdata : ERR_RGB);
    assign {red_out, green_out, blue_out} = pix;

endmodule

// File: doc/line_fetch_buffer.md
LINE_FETCH_BUFFER -- requirements
Module: line_fetch_buffer

Interface
REQ-001 Parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 600, active lines per frame.
REQ-003 Parameter V_TOTAL, default 666, total lines per frame.
REQ-004 Parameter ERR_RGB, default 9'b111_000_111, colour shown on underrun.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 pix_ce  in  1  pixel-period strobe, one clk cycle wide.
REQ-008 h_count  in  11  horizontal position from timing generator, 0..1039.
REQ-009 v_count  in  10  vertical position from timing generator, 0..V_TOTAL-1.
REQ-010 mem_req  out  1  frame-memory read request.
REQ-011 mem_addr  out  19  pixel address, line*H_ACTIVE + x.
REQ-012 mem_ack  in  1  one-cycle acknowledge; mem_rdata valid that cycle.
REQ-013 mem_rdata  in  9  pixel {R[2:0],G[2:0],B[2:0]}.
REQ-014 red_out, green_out, blue_out  out  3 each  registered pixel colour.
REQ-015 underrun_cnt  out  16  saturating count of underrun lines.

Function
REQ-016 Two line banks of H_ACTIVE x 9 bits; display bank = v_count[0], fetch bank = ~v_count[0].
REQ-017 Fetch trigger: pix_ce with h_count==0 and (v_count < V_ACTIVE-1 or v_count == V_TOTAL-1).
REQ-018 Target line: v_count+1, or 0 when v_count == V_TOTAL-1; base address = target*H_ACTIVE, from an accumulator (+H_ACTIVE per fetch, cleared for line 0), no multiplier.
REQ-019 FSM IDLE -> FETCH on trigger; clears bank_ok[fetch bank], x_fetch = 0.
REQ-020 FETCH: mem_req high, mem_addr = base + x_fetch, both stable until mem_ack.
REQ-021 On mem_ack: write mem_rdata at x_fetch into fetch bank, x_fetch++; request for next address may be presented the following cycle (one pixel per cycle max).
REQ-022 mem_ack on x_fetch == H_ACTIVE-1 -> DONE: mem_req low next cycle, bank_ok[fetch bank] set.
REQ-023 DONE -> IDLE unconditionally next cycle.
REQ-024 Trigger while in FETCH: abort (bank stays not-ok), restart immediately for new target; an outstanding ack in the same cycle as trigger is dropped.
REQ-025 mem_ack while mem_req low is ignored.
REQ-026 Output updates only on pix_ce, one pixel-period latency from (h_count,v_count) sampled that cycle.
REQ-027 Active pixel (h_count < H_ACTIVE, v_count < V_ACTIVE): display bank word h_count if bank_ok, else ERR_RGB.
REQ-028 Outside active region: RGB = 0.
REQ-029 underrun_cnt increments at pix_ce with h_count==0, v_count < V_ACTIVE, display bank not ok; saturates at 16'hFFFF.
REQ-030 Trigger ignored when v_count in V_ACTIVE-1..V_TOTAL-2 (no fetch during vertical blank except line 0 prefetch).

Reset
REQ-031 rst: FSM IDLE, mem_req 0, mem_addr 0, x_fetch 0, base 0, bank_ok 2'b00, RGB 0, underrun_cnt 0.
REQ-032 Reset mid-fetch: mem_req drops asynchronously; bank contents untouched but not-ok.
REQ-033 First displayed line after reset without prior line-0 prefetch counts as underrun.

Structure
REQ-034 H_ACTIVE, V_ACTIVE, V_TOTAL, H_TOTAL (1040), sync positions belong in shared package vga_timing_pkg, shared with the timing generator.
REQ-035 Banks in one sub-module line_ram: 2*H_ACTIVE x 9, one write port, one synchronous read port, address {bank, x}.

Verification
REQ-036 Reset, full frame with zero-latency memory returning addr[8:0] -> line 1 pixel 5 outputs 9'(805), underrun_cnt == 1 (line 0 of first frame only).
REQ-037 Second frame, same memory -> underrun_cnt stays 1, line 0 pixel 0 = 0, line 599 pixel 799 = 9'(479999).
REQ-038 mem_ack delayed 3 cycles each -> fetch exceeds line, abort every line; all active pixels ERR_RGB, underrun_cnt +600 per frame.
REQ-039 Spurious mem_ack with mem_req low -> no bank write, x_fetch unchanged.
REQ-040 rst asserted at x_fetch==400 in FETCH -> mem_req 0 same cycle, all outputs reset values, bank_ok 0.
REQ-041 Blanking check: h_count 800..1039 or v_count 600..665 -> RGB 0 one pix_ce later.
